// File: rtl/resv_pkg.sv
// Shared constants and state encoding for the pipeline-1 reservation station
// sequencer and its picker.
package resv_pkg;

    localparam int N_CELLS = 8;
    localparam int W_IDENT = 4;

    // All-ones ident means "no cell". It compares above every real ident.
    localparam logic [W_IDENT-1:0] UNUSED_CD = 4'b1111;
    localparam logic [W_IDENT-1:0] CELLS_CD  = W_IDENT'(N_CELLS);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/resv_pick_oldest.sv
// Lowest-index (oldest) candidate picker over a packed per-cell candit bus.
module resv_pick_oldest
    import resv_pkg::*;
(
    input  logic [N_CELLS*W_IDENT-1:0] candit_bus,
    output logic                       found,
    output logic [W_IDENT-1:0]         ident
);

    // Scanning from the top down lets the lowest candidate overwrite the rest.
    always_comb begin
        found = 1'b0;
        ident = UNUSED_CD;
        for (int k = N_CELLS - 1; k >= 0; k--) begin
            if (candit_bus[k*W_IDENT +: W_IDENT] != UNUSED_CD) begin
                found = 1'b1;
                ident = W_IDENT'(k);
            end
        end
    end

endmodule

// File: rtl/resv_sched_pip1.sv
// Pipeline-1 reservation station sequencer: issue pick, compaction shift,
// decoder insert, occupancy count and init/flush clear sequencing.
module resv_sched_pip1
    import resv_pkg::*;
(
    input  logic                       clk,
    input  logic                       clear_n,
    input  logic [N_CELLS*W_IDENT-1:0] candit0_bus,
    input  logic [N_CELLS*W_IDENT-1:0] candit1_bus,
    input  logic                       exu0_ready,
    input  logic                       exu1_ready,
    input  logic                       ins_valid,
    output logic                       ins_ready,
    input  logic                       flush_req,
    output logic [W_IDENT-1:0]         addr_insert,
    output logic [W_IDENT-1:0]         addr_shift,
    output logic                       cell_clear,
    output logic                       iss0_valid,
    output logic                       iss1_valid,
    output logic [W_IDENT-1:0]         iss_idx,
    output logic [W_IDENT-1:0]         count,
    output logic                       full,
    output logic [1:0]                 dbg_state
);

    // Decoder handshake: an op is written into cell addr_insert on every
    // rising edge where ins_valid && ins_ready; ins_ready never waits on
    // ins_valid, and ins_valid may drop without being accepted.

    state_t             state_q, state_d;
    logic [W_IDENT-1:0] count_q;
    logic               prio_q;

    logic               found0, found1;
    logic [W_IDENT-1:0] id0, id1;
    logic               active, c0, c1, pick1, issue, accept;

    resv_pick_oldest u_pick0 (
        .candit_bus (candit0_bus),
        .found      (found0),
        .ident      (id0)
    );

    resv_pick_oldest u_pick1 (
        .candit_bus (candit1_bus),
        .found      (found1),
        .ident      (id1)
    );

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  state_d = ST_RUN;
            ST_RUN:   if (flush_req) state_d = ST_FLUSH;
            ST_FLUSH: if (!flush_req) state_d = ST_RUN;
            default:  state_d = ST_INIT;
        endcase
    end

    // A flush request squashes issue and insert in the very cycle it arrives.
    assign active = (state_q == ST_RUN) && !flush_req;
    assign c0     = active && found0 && exu0_ready;
    assign c1     = active && found1 && exu1_ready;

    // Only one shift bus, so at most one issue; pip1 wins on age or when its
    // starvation flag is set.
    assign pick1  = c1 && (!c0 || prio_q || (id1 < id0));
    assign issue  = c0 || c1;

    assign iss1_valid = pick1;
    assign iss0_valid = c0 && !pick1;
    assign iss_idx    = pick1 ? id1 : (c0 ? id0 : UNUSED_CD);
    assign addr_shift = iss_idx;

    assign ins_ready   = active && ((count_q < CELLS_CD) || issue);
    assign accept      = ins_valid && ins_ready;
    // With a shift in flight the free slot moves down by one.
    assign addr_insert = !accept ? UNUSED_CD
                       : (issue ? count_q - 1'b1 : count_q);

    assign cell_clear = (state_q != ST_RUN);
    assign count      = count_q;
    assign full       = (count_q == CELLS_CD);
    assign dbg_state  = state_q;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            count_q <= '0;
            prio_q  <= 1'b0;
        end else begin
            if (state_q != ST_RUN) begin
                count_q <= '0;
            end else if (accept && !issue) begin
                count_q <= count_q + 1'b1;
            end else if (issue && !accept) begin
                count_q <= count_q - 1'b1;
            end

            if (iss1_valid) begin
                prio_q <= 1'b0;
            end else if (iss0_valid && c1) begin
                prio_q <= 1'b1;
            end
        end
    end

    // An issue from an empty station would wrap the occupancy count.
    always_ff @(posedge clk) begin
        if (clear_n && issue && !accept) begin
            assert (count_q != '0);
        end
    end

endmodule

// File: tb/tb_resv_sched_pip1.sv
// Directed bench for resv_sched_pip1: reset/init, insert, issue, full,
// anti-starvation priority, flush and asynchronous clear.
module tb_resv_sched_pip1;
    import resv_pkg::*;

    logic        clk;
    logic        clear_n;
    logic [31:0] cand0, cand1;
    logic        exu0_ready, exu1_ready;
    logic        ins_valid, ins_ready, flush_req;
    logic [3:0]  addr_insert, addr_shift, iss_idx, count;
    logic        cell_clear, iss0_valid, iss1_valid, full;
    logic [1:0]  dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    resv_sched_pip1 dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .candit0_bus (cand0),
        .candit1_bus (cand1),
        .exu0_ready  (exu0_ready),
        .exu1_ready  (exu1_ready),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .flush_req   (flush_req),
        .addr_insert (addr_insert),
        .addr_shift  (addr_shift),
        .cell_clear  (cell_clear),
        .iss0_valid  (iss0_valid),
        .iss1_valid  (iss1_valid),
        .iss_idx     (iss_idx),
        .count       (count),
        .full        (full),
        .dbg_state   (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver helpers: inputs only ever change just after a falling edge.
    task automatic idle_inputs();
        cand0      = '1;
        cand1      = '1;
        exu0_ready = 1'b0;
        exu1_ready = 1'b0;
        ins_valid  = 1'b0;
        flush_req  = 1'b0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_n = 1'b0;
        idle_inputs();
        repeat (2) next_cycle();
        n_total++; if (cell_clear !== 1'b1) $display("FAIL rst_cell_clear got %b want 1", cell_clear); else n_pass++;
        n_total++; if (ins_ready !== 1'b0) $display("FAIL rst_ins_ready got %b want 0", ins_ready); else n_pass++;
        n_total++; if (count !== 4'd0) $display("FAIL rst_count got %0d want 0", count); else n_pass++;
        n_total++; if (iss_idx !== 4'hF || addr_shift !== 4'hF || addr_insert !== 4'hF)
            $display("FAIL rst_addrs got idx=%h sh=%h ins=%h want f f f", iss_idx, addr_shift, addr_insert); else n_pass++;
        n_total++; if (full !== 1'b0 || iss0_valid !== 1'b0 || iss1_valid !== 1'b0)
            $display("FAIL rst_flags got full=%b v0=%b v1=%b want 0 0 0", full, iss0_valid, iss1_valid); else n_pass++;
        clear_n = 1'b1;
        #1;
        n_total++; if (dbg_state !== 2'd0 || cell_clear !== 1'b1 || ins_ready !== 1'b0)
            $display("FAIL init_cycle got st=%0d clr=%b rdy=%b want 0 1 0", dbg_state, cell_clear, ins_ready); else n_pass++;
        next_cycle();
        #1;
        n_total++; if (dbg_state !== 2'd1 || cell_clear !== 1'b0 || ins_ready !== 1'b1 || count !== 4'd0)
            $display("FAIL run_entry got st=%0d clr=%b rdy=%b cnt=%0d want 1 0 1 0", dbg_state, cell_clear, ins_ready, count); else n_pass++;
    endtask

    task automatic test_insert();
        for (int i = 0; i < 3; i++) begin
            ins_valid = 1'b1;
            #1;
            n_total++; if (ins_ready !== 1'b1 || addr_insert !== 4'(i))
                $display("FAIL insert_%0d got rdy=%b addr=%0d want 1 %0d", i, ins_ready, addr_insert, i); else n_pass++;
            next_cycle();
        end
        ins_valid = 1'b0;
        #1;
        n_total++; if (count !== 4'd3 || addr_insert !== 4'hF)
            $display("FAIL insert_count got cnt=%0d addr=%h want 3 f", count, addr_insert); else n_pass++;
    endtask

    task automatic test_issue();
        cand0[0 +: 4] = 4'h2;
        #1;
        n_total++; if (iss0_valid !== 1'b0 || iss_idx !== 4'hF)
            $display("FAIL issue_gated got v0=%b idx=%h want 0 f", iss0_valid, iss_idx); else n_pass++;
        cand0      = '1;
        cand0[4 +: 4] = 4'h2;
        exu0_ready = 1'b1;
        #1;
        n_total++; if (iss0_valid !== 1'b1 || iss1_valid !== 1'b0 || iss_idx !== 4'd1 || addr_shift !== 4'd1)
            $display("FAIL issue_cell1 got v0=%b v1=%b idx=%0d sh=%0d want 1 0 1 1", iss0_valid, iss1_valid, iss_idx, addr_shift); else n_pass++;
        next_cycle();
        idle_inputs();
        #1;
        n_total++; if (count !== 4'd2 || iss0_valid !== 1'b0 || addr_shift !== 4'hF)
            $display("FAIL issue_after got cnt=%0d v0=%b sh=%h want 2 0 f", count, iss0_valid, addr_shift); else n_pass++;
    endtask

    task automatic test_full();
        ins_valid = 1'b1;
        repeat (6) next_cycle();
        #1;
        n_total++; if (count !== 4'd8 || full !== 1'b1 || ins_ready !== 1'b0 || addr_insert !== 4'hF)
            $display("FAIL full_block got cnt=%0d full=%b rdy=%b ins=%h want 8 1 0 f", count, full, ins_ready, addr_insert); else n_pass++;
        cand0[8 +: 4] = 4'h5;
        exu0_ready    = 1'b1;
        #1;
        n_total++; if (ins_ready !== 1'b1 || addr_insert !== 4'd7 || addr_shift !== 4'd2 || iss0_valid !== 1'b1)
            $display("FAIL full_issue got rdy=%b ins=%0d sh=%0d v0=%b want 1 7 2 1", ins_ready, addr_insert, addr_shift, iss0_valid); else n_pass++;
        next_cycle();
        idle_inputs();
        #1;
        n_total++; if (count !== 4'd8 || full !== 1'b1)
            $display("FAIL full_after got cnt=%0d full=%b want 8 1", count, full); else n_pass++;
    endtask

    task automatic test_prio();
        exu0_ready = 1'b1;
        exu1_ready = 1'b1;
        // cell0 pip0 vs cell1 pip1: older pip0 wins and raises the flag
        cand0 = '1; cand1 = '1; cand0[0 +: 4] = 4'h1; cand1[4 +: 4] = 4'h1;
        #1;
        n_total++; if (iss0_valid !== 1'b1 || iss1_valid !== 1'b0 || iss_idx !== 4'd0)
            $display("FAIL prio_step1 got v0=%b v1=%b idx=%0d want 1 0 0", iss0_valid, iss1_valid, iss_idx); else n_pass++;
        next_cycle();
        // former cell1 has shifted down to cell0
        cand0 = '1; cand1 = '1; cand1[0 +: 4] = 4'h1;
        #1;
        n_total++; if (iss0_valid !== 1'b0 || iss1_valid !== 1'b1 || iss_idx !== 4'd0)
            $display("FAIL prio_step2 got v0=%b v1=%b idx=%0d want 0 1 0", iss0_valid, iss1_valid, iss_idx); else n_pass++;
        next_cycle();
        cand0 = '1; cand1 = '1; cand0[0 +: 4] = 4'h1; cand1[4 +: 4] = 4'h1;
        #1;
        n_total++; if (iss0_valid !== 1'b1 || iss_idx !== 4'd0)
            $display("FAIL prio_step3 got v0=%b idx=%0d want 1 0", iss0_valid, iss_idx); else n_pass++;
        next_cycle();
        // flag set: the younger pip1 candidate beats the older pip0 one
        cand0 = '1; cand1 = '1; cand0[0 +: 4] = 4'h1; cand1[8 +: 4] = 4'h1;
        #1;
        n_total++; if (iss0_valid !== 1'b0 || iss1_valid !== 1'b1 || iss_idx !== 4'd2 || addr_shift !== 4'd2)
            $display("FAIL prio_step4 got v0=%b v1=%b idx=%0d sh=%0d want 0 1 2 2", iss0_valid, iss1_valid, iss_idx, addr_shift); else n_pass++;
        next_cycle();
        cand0 = '1; cand1 = '1; cand0[0 +: 4] = 4'h1; cand1[4 +: 4] = 4'h1;
        #1;
        n_total++; if (iss0_valid !== 1'b1 || iss1_valid !== 1'b0 || iss_idx !== 4'd0)
            $display("FAIL prio_step5 got v0=%b v1=%b idx=%0d want 1 0 0", iss0_valid, iss1_valid, iss_idx); else n_pass++;
        next_cycle();
        idle_inputs();
        #1;
        n_total++; if (count !== 4'd3)
            $display("FAIL prio_count got %0d want 3", count); else n_pass++;
    endtask

    task automatic test_flush();
        ins_valid = 1'b1;
        repeat (2) next_cycle();
        flush_req     = 1'b1;
        cand0[0 +: 4] = 4'h3;
        exu0_ready    = 1'b1;
        #1;
        n_total++; if (iss0_valid !== 1'b0 || ins_ready !== 1'b0 || addr_insert !== 4'hF || addr_shift !== 4'hF || cell_clear !== 1'b0)
            $display("FAIL flush_req_cycle got v0=%b rdy=%b ins=%h sh=%h clr=%b want 0 0 f f 0",
                     iss0_valid, ins_ready, addr_insert, addr_shift, cell_clear); else n_pass++;
        next_cycle();
        #1;
        n_total++; if (dbg_state !== 2'd2 || cell_clear !== 1'b1 || ins_ready !== 1'b0 || iss0_valid !== 1'b0)
            $display("FAIL flush_state got st=%0d clr=%b rdy=%b v0=%b want 2 1 0 0", dbg_state, cell_clear, ins_ready, iss0_valid); else n_pass++;
        next_cycle();
        #1;
        n_total++; if (dbg_state !== 2'd2 || count !== 4'd0)
            $display("FAIL flush_hold got st=%0d cnt=%0d want 2 0", dbg_state, count); else n_pass++;
        idle_inputs();
        next_cycle();
        #1;
        n_total++; if (dbg_state !== 2'd1 || cell_clear !== 1'b0 || count !== 4'd0 || ins_ready !== 1'b1)
            $display("FAIL flush_exit got st=%0d clr=%b cnt=%0d rdy=%b want 1 0 0 1", dbg_state, cell_clear, count, ins_ready); else n_pass++;
    endtask

    task automatic test_async_clear();
        ins_valid = 1'b1;
        repeat (2) next_cycle();
        ins_valid = 1'b0;
        #1;
        n_total++; if (count !== 4'd2)
            $display("FAIL aclr_pre got %0d want 2", count); else n_pass++;
        #2;
        clear_n = 1'b0;
        #1;
        n_total++; if (count !== 4'd0 || cell_clear !== 1'b1 || dbg_state !== 2'd0 || ins_ready !== 1'b0)
            $display("FAIL aclr_now got cnt=%0d clr=%b st=%0d rdy=%b want 0 1 0 0", count, cell_clear, dbg_state, ins_ready); else n_pass++;
        next_cycle();
        clear_n = 1'b1;
        repeat (2) next_cycle();
    endtask

    initial begin
        test_reset();
        test_insert();
        test_issue();
        test_full();
        test_prio();
        test_flush();
        test_async_clear();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
